// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the RV32M multiply/divide unit.
// Holds funct3 codes, FSM state codes and operand-sign helpers.
package muldiv_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREP   = 2'd1;
    localparam logic [1:0] S_CALC   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic sgn_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic sgn_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Magnitude of a word, negating only when it is signed and negative
    function automatic logic [XLEN_DEF-1:0] mag(
        input logic [XLEN_DEF-1:0] v,
        input logic                s
    );
        return (s && v[XLEN_DEF-1]) ? ('0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, fixed 34-cycle latency.
// One 33-bit adder/subtractor serves both shift-add and restoring divide.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      addr_rd_in,
    output logic            busy,
    output logic            done,
    output logic            we,
    output logic [4:0]      addr_rd,
    output logic [XLEN-1:0] result
);

    logic [1:0]      state;
    logic [2:0]      op;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] m_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [4:0]      cnt;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic            rneg_q;
    logic            sa;
    logic            sb;

    logic [XLEN:0]     add_x;
    logic [XLEN:0]     add_y;
    logic [XLEN+1:0]   add_sum;
    logic              carry;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_res;

    assign busy  = (state != S_IDLE);
    assign sa    = sgn_a(op) & a_q[XLEN-1];
    assign sb    = sgn_b(op) & b_q[XLEN-1];
    assign carry = add_sum[XLEN+1];

    // Shared adder: adds the multiplicand, or subtracts the divisor
    always_comb begin
        add_x   = op[2] ? {hi, lo[XLEN-1]} : {1'b0, hi};
        add_y   = op[2] ? ~{1'b0, m_q} : {1'b0, m_q};
        add_sum = {1'b0, add_x} + {1'b0, add_y}
                + {{(XLEN+1){1'b0}}, op[2]};
    end

    // Sign correction, special cases and output selection
    always_comb begin
        prod    = {hi, lo};
        prod_s  = neg_q ? ('0 - prod) : prod;
        quo     = neg_q ? ('0 - lo) : lo;
        rem     = rneg_q ? ('0 - hi) : hi;
        fin_res = prod_s[XLEN-1:0];
        case (op)
            F3_MUL:    fin_res = prod_s[XLEN-1:0];
            F3_MULH,
            F3_MULHSU,
            F3_MULHU:  fin_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV,
            F3_DIVU:   fin_res = (m_q == '0) ? '1 : quo;
            F3_REM,
            F3_REMU:   fin_res = (m_q == '0) ? a_q : rem;
            default:   fin_res = prod_s[XLEN-1:0];
        endcase
    end

    // Control FSM and iterative datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
            result  <= '0;
            addr_rd <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        rd_q  <= addr_rd_in;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    lo     <= op[2] ? mag(a_q, sgn_a(op)) : mag(b_q, sgn_b(op));
                    m_q    <= op[2] ? mag(b_q, sgn_b(op)) : mag(a_q, sgn_a(op));
                    hi     <= '0;
                    cnt    <= '0;
                    neg_q  <= sa ^ sb;
                    rneg_q <= sa;
                    state  <= S_CALC;
                end
                S_CALC: begin
                    if (op[2]) begin
                        hi <= carry ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], carry};
                    end else if (lo[0]) begin
                        {hi, lo} <= {add_sum[XLEN:0], lo[XLEN-1:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    result  <= fin_res;
                    addr_rd <= rd_q;
                    done    <= 1'b1;
                    we      <= (rd_q != 5'd0);
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Reference model uses plain integer arithmetic and a cycle countdown.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  addr_rd_in;
    logic        busy;
    logic        done;
    logic        we;
    logic [4:0]  addr_rd;
    logic [31:0] result;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct3     (funct3),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .addr_rd_in (addr_rd_in),
        .busy       (busy),
        .done       (done),
        .we         (we),
        .addr_rd    (addr_rd),
        .result     (result)
    );

    function automatic logic [31:0] ref_op(
        input logic [2:0]  f,
        input logic [31:0] a,
        input logic [31:0] b
    );
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    int          m_left;
    logic        m_done;
    logic [31:0] m_res;
    logic [31:0] p_res;
    logic [4:0]  m_rd;
    logic [4:0]  p_rd;

    // Reference: an accepted start yields done exactly 34 edges later
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_rd   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= p_res;
                    m_rd   <= p_rd;
                end
            end else if (start) begin
                m_left <= 34;
                p_res  <= ref_op(funct3, operand_a, operand_b);
                p_rd   <= addr_rd_in;
            end
        end
    end

    // Every cycle, outputs must match the reference
    always @(posedge clk) begin
        #1;
        chk("busy", busy, m_left > 0);
        chk("done", done, m_done);
        chk("we", we, m_done && (m_rd != 0));
        chk("result", result, m_res);
        chk("addr_rd", addr_rd, m_rd);
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        funct3     = f;
        operand_a  = a;
        operand_b  = b;
        addr_rd_in = rd;
        start      = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        bit found;
        found = 0;
        k = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (done) found = 1;
        end
        if (!found) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] expv);
        int k;
        drive(f, a, b, rd);
        wait_done(k);
        chk("latency", k, 34);
        chk("lit_result", result, expv);
        chk("lit_we", we, rd != 0);
        chk("lit_rd", addr_rd, rd);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        int nd;
        rst        = 1'b0;
        start      = 1'b0;
        funct3     = '0;
        operand_a  = '0;
        operand_b  = '0;
        addr_rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", addr_rd, 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
        run_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

        // starts while busy are ignored
        drive(3'd0, 32'd5, 32'd6, 5'd3);
        nd = 0;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            if (c == 10 || c == 20) begin
                start     = 1'b1;
                funct3    = 3'd4;
                operand_a = 32'd77;
                operand_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("ignored_starts_ndone", nd, 1);
        chk("ignored_starts_res", result, 30);

        // start held through the done cycle is taken next
        drive(3'd0, 32'd3, 32'd5, 5'd7);
        repeat (33) @(posedge clk);
        @(negedge clk);
        funct3     = 3'd0;
        operand_a  = 32'd9;
        operand_b  = 32'd9;
        addr_rd_in = 5'd8;
        start      = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_first_done", done, 1);
        chk("b2b_first_res", result, 15);
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(k);
        chk("b2b_latency", k, 34);
        chk("b2b_second_res", result, 81);

        // reset mid-operation
        drive(3'd4, 32'd100, 32'd7, 5'd4);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_we", we, 0);
        chk("abort_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_op(3'd0, 32'd3, 32'd4, 5'd9, 32'd12);
        run_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12);

        // random traffic, including starts while busy
        repeat (6000) begin
            @(negedge clk);
            start      = ($urandom_range(0, 3) == 0);
            funct3     = 3'($urandom_range(0, 7));
            operand_a  = pick();
            operand_b  = pick();
            addr_rd_in = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
